// File: rtl/aline_mem_writer.sv
// aline_mem_writer
//   Avalon-MM initiator that packs a 16-bit A-line sample stream two samples
//   per 32-bit word and writes a run of words into the single-port on-chip
//   sample memory, starting at a programmable base address and wrapping at
//   MEM_DEPTH. It pulses done when the run is complete.
//
//   Optional feature macro: READBACK_VERIFY_EN
//     When defined, a wrapping 32-bit sum of the written words is kept, the
//     run is read back (N back-to-back reads, one flush cycle for the 1-cycle
//     read latency) and verify_err flags a checksum mismatch at done.
//     When undefined, there are no read cycles and verify_err is tied low.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             run request, sampled only while idle
//   base_addr         first word address of the run
//   num_words         number of words to write (0 gives an immediate done)
//   smp_data/valid    sample stream input; smp_ready is the accept handshake
//   busy, done        run in progress / one-cycle completion pulse
//   verify_err        readback checksum mismatch, sticky until next start
//   mem_*             Avalon-MM master port to the sample memory
//   mem_readdata      read data, valid the cycle after a read strobe
module aline_mem_writer #(
  parameter int MEM_DEPTH = 128000,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [15:0]       smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

`ifdef READBACK_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FILL_LO, S_FILL_HI, S_VERIFY, S_FLUSH, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FILL_LO, S_FILL_HI, S_DONE
  } state_t;
`endif

  // Next word address with wrap at the memory depth.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(MEM_DEPTH - 1)) return '0;
    else return a + ADDR_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [15:0]       lo_q, lo_d;
  logic              smp_ready_q, smp_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              xfer;

`ifdef READBACK_VERIFY_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [31:0]       wsum_q, wsum_d;
  logic [31:0]       rsum_q, rsum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              verr_q, verr_d;
`else
  logic              unused_readdata;
  assign unused_readdata = ^mem_readdata;
`endif

  assign xfer = smp_valid && smp_ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    be_d    = be_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
`ifdef READBACK_VERIFY_EN
    base_d    = base_q;
    num_d     = num_q;
    wsum_d    = wsum_q;
    // Read data lands one cycle after each read strobe.
    rsum_d    = rsum_q + (rd_pend_q ? mem_readdata : 32'h0);
    rd_pend_d = cs_q && !we_q;
    verr_d    = verr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef READBACK_VERIFY_EN
          verr_d = 1'b0;
          wsum_d = '0;
          rsum_d = '0;
          base_d = base_addr;
          num_d  = num_words;
`endif
          if (num_words == '0) begin
            // Empty run: pulse done directly on the next cycle.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL_LO;
            addr_d  = base_addr;
            rem_d   = num_words;
          end
        end
      end

      S_FILL_LO: begin
        if (xfer) begin
          lo_d    = smp_data;
          state_d = S_FILL_HI;
        end
      end

      S_FILL_HI: begin
        if (xfer) begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          be_d    = 4'hF;
          maddr_d = addr_q;
          wdata_d = {smp_data, lo_q};
          addr_d  = addr_inc(addr_q);
          rem_d   = rem_q - ADDR_W'(1);
`ifdef READBACK_VERIFY_EN
          wsum_d  = wsum_q + {smp_data, lo_q};
`endif
          if (rem_q == ADDR_W'(1)) begin
`ifdef READBACK_VERIFY_EN
            // Rewind to the start of the run for the readback pass.
            state_d = S_VERIFY;
            addr_d  = base_q;
            rem_d   = num_q;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_FILL_LO;
          end
        end
      end

`ifdef READBACK_VERIFY_EN
      S_VERIFY: begin
        cs_d    = 1'b1;
        we_d    = 1'b0;
        be_d    = 4'hF;
        maddr_d = addr_q;
        addr_d  = addr_inc(addr_q);
        rem_d   = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1)) state_d = S_FLUSH;
      end

      S_FLUSH: begin
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        // The empty run already raised done on entry; a full run raises it here.
        done_d  = !done_q;
        state_d = S_IDLE;
`ifdef READBACK_VERIFY_EN
        verr_d  = (rsum_d != wsum_q);
`endif
      end

      default: state_d = S_IDLE;
    endcase

    smp_ready_d = (state_d == S_FILL_LO) || (state_d == S_FILL_HI);
    busy_d      = (state_d != S_IDLE) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      smp_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      maddr_q     <= '0;
      wdata_q     <= '0;
`ifdef READBACK_VERIFY_EN
      base_q      <= '0;
      num_q       <= '0;
      wsum_q      <= '0;
      rsum_q      <= '0;
      rd_pend_q   <= 1'b0;
      verr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      smp_ready_q <= smp_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      be_q        <= be_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
`ifdef READBACK_VERIFY_EN
      base_q      <= base_d;
      num_q       <= num_d;
      wsum_q      <= wsum_d;
      rsum_q      <= rsum_d;
      rd_pend_q   <= rd_pend_d;
      verr_q      <= verr_d;
`endif
    end
  end

  assign smp_ready      = smp_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = maddr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;
`ifdef READBACK_VERIFY_EN
  assign verify_err     = verr_q;
`else
  assign verify_err     = 1'b0;
`endif

endmodule
